cmp_serial_nb: RTL and testbench

//   Multi-cycle unsigned magnitude comparator for WIDTH-bit operands.

---
 rtl/cmp_serial_nb.sv | 110 +++++++++++
 tb/tb_cmp_serial_nb.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_serial_nb.sv
// cmp_serial_nb
//   Multi-cycle unsigned magnitude comparator for WIDTH-bit operands.
//   Compares one 2-bit digit pair per clock, starting with the most
//   significant pair. It stops on the first unequal pair.
//   The result is one-hot: eq (x==y), lt (x<y) or gt (x>y).
//   A start/busy/done handshake controls each comparison.
//
// Parameters
//   WIDTH  operand width in bits; must be even and >= 2 (N = WIDTH/2 digits)
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous, active-low reset
//   start  in   1      request a compare; only sampled while idle
//   x      in   WIDTH  operand x, unsigned; captured when start is accepted
//   y      in   WIDTH  operand y, unsigned; captured when start is accepted
//   busy   out  1      high while digits are being compared
//   done   out  1      one-cycle pulse marking a valid result
//   eq     out  1      registered x==y result
//   lt     out  1      registered x<y result
//   gt     out  1      registered x>y result

module cmp_serial_nb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [CW-1:0]    cnt;
  logic [1:0]       x_dig;
  logic [1:0]       y_dig;

  // The digit under comparison is always the top pair of each shift register.
  assign x_dig = xs[WIDTH-1 -: 2];
  assign y_dig = ys[WIDTH-1 -: 2];

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xs    <= '0;
      ys    <= '0;
      cnt   <= '0;
      eq    <= 1'b0;
      lt    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            xs    <= x;
            ys    <= y;
            cnt   <= CW'(N - 1);
            eq    <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          // The first unequal digit pair decides the result. Lower digits
          // cannot change it, so the compare finishes here.
          if (x_dig != y_dig) begin
            if (x_dig > y_dig) begin
              gt <= 1'b1;
            end else begin
              lt <= 1'b1;
            end
            state <= DONE;
          end else if (cnt == '0) begin
            eq    <= 1'b1;
            state <= DONE;
          end else begin
            xs    <= xs << 2;
            ys    <= ys << 2;
            cnt   <= cnt - CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_serial_nb.sv
// tb_cmp_serial_nb
//   Self-checking bench for cmp_serial_nb.
//   One instance uses WIDTH=8 and runs the directed scenarios.
//   A second instance uses WIDTH=4 and runs the exhaustive operand sweep.
//   Expected results and latencies are pushed to a queue when a compare is
//   requested. They are popped when done is seen.

module tb_cmp_serial_nb;

  typedef struct packed {
    logic       eq;
    logic       lt;
    logic       gt;
    logic [3:0] lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] x8 = '0;
  logic [7:0] y8 = '0;
  logic       busy8, done8, eq8, lt8, gt8;

  logic       start4 = 1'b0;
  logic [3:0] x4 = '0;
  logic [3:0] y4 = '0;
  logic       busy4, done4, eq4, lt4, gt4;

  exp_t sb8[$];
  exp_t sb4[$];

  int check_count = 0;
  int pass_count  = 0;

  always #5 clk = ~clk;

  cmp_serial_nb #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .eq(eq8), .lt(lt8), .gt(gt8)
  );

  cmp_serial_nb #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .x(x4), .y(y4),
    .busy(busy4), .done(done4), .eq(eq4), .lt(lt4), .gt(gt4)
  );

  // Behavioural reference. The result comes from plain integer compares.
  // The latency is k+1, where k is the index of the first differing digit
  // counted from the MSB pair, or n-1 when all digits match.
  function automatic exp_t model(input int n, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   k;
    logic [7:0] da, db;
    e.eq = (a == b);
    e.lt = (a < b);
    e.gt = (a > b);
    k = n - 1;
    for (int i = 0; i < n; i++) begin
      da = (a >> (2 * (n - 1 - i))) & 8'd3;
      db = (b >> (2 * (n - 1 - i))) & 8'd3;
      if (da != db) begin
        k = i;
        break;
      end
    end
    e.lat = 4'(k + 1);
    return e;
  endfunction

  // Raises start8 and holds it until the compare is accepted. Returns with
  // start8 low, #1 after the accepting edge.
  task automatic start_cmp8(input logic [7:0] a, input logic [7:0] b, output bit accepted);
    start8 = 1'b1;
    x8 = a;
    y8 = b;
    sb8.push_back(model(4, a, b));
    accepted = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (busy8) begin
        accepted = 1'b1;
        break;
      end
    end
    start8 = 1'b0;
  endtask

  // Counts edges after acceptance until done8 is seen, within a bound.
  // busy_cycles includes the cycle right after the accepting edge.
  task automatic wait_done8(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (busy8) busy_cycles++;
      if (done8) break;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_count++;
    if ({busy8, done8} !== 2'b00) $display("[TB] FAIL reset_busy_done: got %b want 00", {busy8, done8});
    else pass_count++;
    check_count++;
    if ({eq8, lt8, gt8} !== 3'b000) $display("[TB] FAIL reset_result: got %b want 000", {eq8, lt8, gt8});
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_count++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b00000)
      $display("[TB] FAIL post_reset_idle: got %b want 00000", {busy8, done8, eq8, lt8, gt8});
    else pass_count++;
  endtask

  task automatic test_gt_early;
    bit   acc;
    int   edges, bc;
    exp_t e;
    start_cmp8(8'hC0, 8'h40, acc);
    check_count++;
    if (acc !== 1'b1) $display("[TB] FAIL gt_early_accept: got %b want 1", acc);
    else pass_count++;
    wait_done8(edges, bc);
    e = sb8.pop_front();
    check_count++;
    if (edges !== int'(e.lat)) $display("[TB] FAIL gt_early_latency: got %0d want %0d", edges, e.lat);
    else pass_count++;
    check_count++;
    if (bc !== 1) $display("[TB] FAIL gt_early_busy_cycles: got %0d want 1", bc);
    else pass_count++;
    check_count++;
    if ({eq8, lt8, gt8} !== {e.eq, e.lt, e.gt})
      $display("[TB] FAIL gt_early_result: got %b want %b", {eq8, lt8, gt8}, {e.eq, e.lt, e.gt});
    else pass_count++;
    @(posedge clk);
    #1;
  endtask

  // Full-length equal compare. While busy, start is pulsed and the operand
  // inputs are scrambled. start is also held across the edge that leaves DONE.
  task automatic test_eq_ignore_hold;
    bit   acc;
    int   edges, bc, extra_done;
    exp_t e;
    start_cmp8(8'h5A, 8'h5A, acc);
    edges = 0;
    bc = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done8) break;
      if (busy8) begin
        bc++;
        start8 = ~start8;
        x8 = 8'($urandom);
        y8 = ~x8;
      end
    end
    start8 = 1'b1;
    x8 = 8'h00;
    y8 = 8'hFF;
    e = sb8.pop_front();
    check_count++;
    if (edges !== int'(e.lat)) $display("[TB] FAIL eq_latency: got %0d want %0d", edges, e.lat);
    else pass_count++;
    check_count++;
    if (bc !== 4) $display("[TB] FAIL eq_busy_cycles: got %0d want 4", bc);
    else pass_count++;
    check_count++;
    if ({eq8, lt8, gt8} !== {e.eq, e.lt, e.gt})
      $display("[TB] FAIL eq_result: got %b want %b", {eq8, lt8, gt8}, {e.eq, e.lt, e.gt});
    else pass_count++;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    check_count++;
    if ({busy8, done8} !== 2'b00) $display("[TB] FAIL start_in_done_ignored: got %b want 00", {busy8, done8});
    else pass_count++;
    extra_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done8) extra_done++;
    end
    check_count++;
    if (extra_done !== 0) $display("[TB] FAIL single_done_pulse: got %0d extra pulses want 0", extra_done);
    else pass_count++;
    check_count++;
    if ({eq8, lt8, gt8} !== 3'b100) $display("[TB] FAIL eq_held: got %b want 100", {eq8, lt8, gt8});
    else pass_count++;
  endtask

  task automatic test_lt_last;
    bit   acc;
    int   edges, bc;
    exp_t e;
    start_cmp8(8'h12, 8'h13, acc);
    check_count++;
    if ({eq8, lt8, gt8} !== 3'b000) $display("[TB] FAIL result_cleared_on_start: got %b want 000", {eq8, lt8, gt8});
    else pass_count++;
    wait_done8(edges, bc);
    e = sb8.pop_front();
    check_count++;
    if (edges !== int'(e.lat)) $display("[TB] FAIL lt_last_latency: got %0d want %0d", edges, e.lat);
    else pass_count++;
    check_count++;
    if ({eq8, lt8, gt8} !== {e.eq, e.lt, e.gt})
      $display("[TB] FAIL lt_last_result: got %b want %b", {eq8, lt8, gt8}, {e.eq, e.lt, e.gt});
    else pass_count++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    bit   acc;
    int   edges, bc;
    exp_t e;
    start_cmp8(8'h5A, 8'h5A, acc);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb8.pop_front());
    check_count++;
    if ({busy8, done8, eq8, lt8, gt8} !== 5'b00000)
      $display("[TB] FAIL mid_run_reset: got %b want 00000", {busy8, done8, eq8, lt8, gt8});
    else pass_count++;
    @(posedge clk);
    #1;
    check_count++;
    if (done8 !== 1'b0) $display("[TB] FAIL no_done_in_reset: got %b want 0", done8);
    else pass_count++;
    @(negedge clk);
    rst_n = 1'b1;
    start_cmp8(8'h01, 8'h00, acc);
    wait_done8(edges, bc);
    e = sb8.pop_front();
    check_count++;
    if (edges !== int'(e.lat)) $display("[TB] FAIL after_reset_latency: got %0d want %0d", edges, e.lat);
    else pass_count++;
    check_count++;
    if ({eq8, lt8, gt8} !== {e.eq, e.lt, e.gt})
      $display("[TB] FAIL after_reset_result: got %b want %b", {eq8, lt8, gt8}, {e.eq, e.lt, e.gt});
    else pass_count++;
    @(posedge clk);
    #1;
  endtask

  // Every 4-bit operand pair is compared. Each new start is raised as soon
  // as done is seen, so the compares run back to back.
  task automatic test_back_to_back_sweep4;
    int   edges;
    bit   acc;
    exp_t e;
    exp_t g;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        start4 = 1'b1;
        x4 = 4'(a);
        y4 = 4'(b);
        sb4.push_back(model(2, 8'(a), 8'(b)));
        acc = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(posedge clk);
          #1;
          if (busy4) begin
            acc = 1'b1;
            break;
          end
        end
        start4 = 1'b0;
        edges = 0;
        for (int i = 0; i < 10; i++) begin
          @(posedge clk);
          #1;
          edges++;
          if (done4) break;
        end
        e = sb4.pop_front();
        g.eq = eq4;
        g.lt = lt4;
        g.gt = gt4;
        g.lat = acc ? 4'(edges) : 4'hF;
        check_count++;
        if (g !== e)
          $display("[TB] FAIL sweep4 x=%0d y=%0d: got eq/lt/gt=%b lat=%0d want eq/lt/gt=%b lat=%0d",
                   a, b, {g.eq, g.lt, g.gt}, g.lat, {e.eq, e.lt, e.gt}, e.lat);
        else pass_count++;
      end
    end
  endtask

  // The result flags must never have more than one bit set.
  // They must have exactly one bit set whenever done is high.
  always @(negedge clk) begin
    if (rst_n) begin
      if ((eq8 + lt8 + gt8) > 2'd1 || (done8 && (eq8 + lt8 + gt8) != 2'd1))
        $display("[TB] FAIL onehot8: done=%b eq/lt/gt=%b", done8, {eq8, lt8, gt8});
      if ((eq4 + lt4 + gt4) > 2'd1 || (done4 && (eq4 + lt4 + gt4) != 2'd1))
        $display("[TB] FAIL onehot4: done=%b eq/lt/gt=%b", done4, {eq4, lt4, gt4});
    end
  end

  initial begin
    $display("[TB] cmp_serial_nb bench starting");
    test_reset;
    test_gt_early;
    test_eq_ignore_hold;
    test_lt_last;
    test_reset_mid_run;
    test_back_to_back_sweep4;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
